avl_rr_mux: RTL and testbench

Parametrised N-to-1 Avalon-MM burst multiplexer that merges the load/store queue channel masters of spmv_func onto one DDR controller port. It arbitrates round-robin, locks the grant for the full length of write bursts and tracks outstanding reads in a response-ID FIFO. It steers each readdatavalid beat back to the requesting slave port. Supports any slave count, data width and burst width, with bounded outstanding reads.

---
 rtl/avl_rr_mux.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_avl_rr_mux.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/avl_rr_mux.sv
// avl_rr_mux
// N-to-1 Avalon-MM burst multiplexer. Slave channels share one DDR
// controller port. Slaves are arbitrated round-robin, and a write burst
// keeps the grant until its last beat. Outstanding reads are recorded as
// {owner id, burst length} in a small FIFO, so that each returning read
// beat can be steered back to the slave that issued the command.
module avl_rr_mux #(
  parameter int NUM_SLAVES     = 5,
  parameter int ADDR_WIDTH     = 27,
  parameter int DATA_WIDTH     = 576,
  parameter int BURST_WIDTH    = 7,
  parameter int RSP_FIFO_DEPTH = 16
) (
  input  logic                                   clock,
  input  logic                                   resetn,
  input  logic [NUM_SLAVES*ADDR_WIDTH-1:0]       s_address,
  input  logic [NUM_SLAVES-1:0]                  s_read,
  input  logic [NUM_SLAVES-1:0]                  s_write,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0]       s_writedata,
  input  logic [NUM_SLAVES*(DATA_WIDTH/8)-1:0]   s_be,
  input  logic [NUM_SLAVES*BURST_WIDTH-1:0]      s_burstcount,
  output logic [NUM_SLAVES-1:0]                  s_waitrequest,
  output logic [NUM_SLAVES*DATA_WIDTH-1:0]       s_readdata,
  output logic [NUM_SLAVES-1:0]                  s_readdatavalid,
  output logic [ADDR_WIDTH-1:0]                  m_address,
  output logic                                   m_read,
  output logic                                   m_write,
  output logic [DATA_WIDTH-1:0]                  m_writedata,
  output logic [DATA_WIDTH/8-1:0]                m_be,
  output logic [BURST_WIDTH-1:0]                 m_burstcount,
  input  logic                                   m_waitrequest,
  input  logic [DATA_WIDTH-1:0]                  m_readdata,
  input  logic                                   m_readdatavalid,
  output logic                                   err_unexpected_rsp
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int OW       = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int PW       = (RSP_FIFO_DEPTH > 1) ? $clog2(RSP_FIFO_DEPTH) : 1;
  localparam int CW       = PW + 1;

  localparam logic [OW-1:0]          LAST_SLAVE    = OW'(NUM_SLAVES - 1);
  localparam logic [CW-1:0]          FIFO_FULL_CNT = CW'(RSP_FIFO_DEPTH);
  localparam logic [CW-1:0]          CNT_ZERO      = CW'(0);
  localparam logic [CW-1:0]          CNT_ONE       = CW'(1);
  localparam logic [PW-1:0]          PTR_ONE       = PW'(1);
  localparam logic [BURST_WIDTH-1:0] BEAT_ZERO     = BURST_WIDTH'(0);
  localparam logic [BURST_WIDTH-1:0] BEAT_ONE      = BURST_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT  = 2'd1,
    ST_WBURST = 2'd2
  } state_t;

  // Arbitration / command-path state
  state_t                  r_state;
  logic [OW-1:0]           r_owner;
  logic [BURST_WIDTH-1:0]  r_wcnt;

  // Response-ID FIFO and read beat tracking
  logic [OW-1:0]           r_fifo_id  [RSP_FIFO_DEPTH];
  logic [BURST_WIDTH-1:0]  r_fifo_len [RSP_FIFO_DEPTH];
  logic [PW-1:0]           r_wr_ptr;
  logic [PW-1:0]           r_rd_ptr;
  logic [CW-1:0]           r_count;
  logic [BURST_WIDTH-1:0]  r_rcnt;
  logic                    r_err;

  // Combinational helpers
  logic [NUM_SLAVES-1:0]   w_req;
  logic [OW-1:0]           w_next_owner;
  logic [OW-1:0]           w_idx;
  logic                    w_found;
  logic                    w_pick;
  logic [ADDR_WIDTH-1:0]   w_own_addr;
  logic [DATA_WIDTH-1:0]   w_own_wdata;
  logic [BE_WIDTH-1:0]     w_own_be;
  logic [BURST_WIDTH-1:0]  w_own_burst;
  logic [BURST_WIDTH-1:0]  w_own_len;
  logic                    w_own_read;
  logic                    w_own_write;
  state_t                  w_state_eff;
  logic                    w_rd_block;
  logic                    w_accept;
  logic                    w_push;
  logic                    w_pop;
  logic                    w_full;
  logic                    w_empty;
  logic [OW-1:0]           w_head_id;
  logic [BURST_WIDTH-1:0]  w_head_len;
  logic                    w_rsp_hit;

  assign w_req      = s_read | s_write;
  assign w_full     = (r_count == FIFO_FULL_CNT);
  assign w_empty    = (r_count == CNT_ZERO);
  assign w_head_id  = r_fifo_id[r_rd_ptr];
  assign w_head_len = r_fifo_len[r_rd_ptr];

  // A zero burstcount means a single beat.
  assign w_own_len = (w_own_burst == BEAT_ZERO) ? BEAT_ONE : w_own_burst;

  // While reset is asserted, all outputs are the IDLE values.
  assign w_state_eff = resetn ? r_state : ST_IDLE;

  assign w_accept  = (m_read | m_write) & ~m_waitrequest;
  assign w_push    = (w_state_eff == ST_GRANT) & m_read & ~m_waitrequest;
  assign w_rsp_hit = resetn & m_readdatavalid & ~w_empty;
  assign w_pop     = w_rsp_hit & (r_rcnt == (w_head_len - BEAT_ONE));

  assign s_readdata         = {NUM_SLAVES{m_readdata}};
  assign err_unexpected_rsp = r_err;

  // Select the current owner's command fields with an AND-OR mux.
  always_comb begin
    w_own_addr  = {ADDR_WIDTH{1'b0}};
    w_own_wdata = {DATA_WIDTH{1'b0}};
    w_own_be    = {BE_WIDTH{1'b0}};
    w_own_burst = BEAT_ZERO;
    w_own_read  = 1'b0;
    w_own_write = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      w_own_addr  = w_own_addr  | (s_address[i*ADDR_WIDTH +: ADDR_WIDTH]
                                   & {ADDR_WIDTH{r_owner == OW'(i)}});
      w_own_wdata = w_own_wdata | (s_writedata[i*DATA_WIDTH +: DATA_WIDTH]
                                   & {DATA_WIDTH{r_owner == OW'(i)}});
      w_own_be    = w_own_be    | (s_be[i*BE_WIDTH +: BE_WIDTH]
                                   & {BE_WIDTH{r_owner == OW'(i)}});
      w_own_burst = w_own_burst | (s_burstcount[i*BURST_WIDTH +: BURST_WIDTH]
                                   & {BURST_WIDTH{r_owner == OW'(i)}});
      w_own_read  = w_own_read  | (s_read[i]  & (r_owner == OW'(i)));
      w_own_write = w_own_write | (s_write[i] & (r_owner == OW'(i)));
    end
  end

  // Round-robin search: first requester after the current owner, wrapping.
  always_comb begin
    w_next_owner = r_owner;
    w_found      = 1'b0;
    w_pick       = 1'b0;
    w_idx        = r_owner;
    for (int k = 1; k <= NUM_SLAVES; k++) begin
      w_idx        = OW'((int'(r_owner) + k) % NUM_SLAVES);
      w_pick       = ~w_found & w_req[w_idx];
      w_next_owner = w_pick ? w_idx : w_next_owner;
      w_found      = w_found | w_pick;
    end
  end

  // Drive the controller port and per-slave stalls from the granted slave.
  always_comb begin
    m_address     = {ADDR_WIDTH{1'b0}};
    m_read        = 1'b0;
    m_write       = 1'b0;
    m_writedata   = {DATA_WIDTH{1'b0}};
    m_be          = {BE_WIDTH{1'b0}};
    m_burstcount  = BEAT_ZERO;
    s_waitrequest = {NUM_SLAVES{1'b1}};
    w_rd_block    = 1'b0;
    case (w_state_eff)
      ST_GRANT: begin
        // A read is held off while every response slot is occupied.
        w_rd_block   = w_own_read & w_full;
        m_read       = w_own_read & ~w_rd_block;
        m_write      = w_own_write & ~w_rd_block;
        m_address    = w_own_addr;
        m_writedata  = w_own_wdata;
        m_be         = w_own_be;
        m_burstcount = w_own_burst;
        for (int i = 0; i < NUM_SLAVES; i++) begin
          s_waitrequest[i] = (r_owner == OW'(i)) ? (m_waitrequest | w_rd_block) : 1'b1;
        end
      end
      ST_WBURST: begin
        // Burst continuation: only write beats pass.
        m_write      = w_own_write;
        m_address    = w_own_addr;
        m_writedata  = w_own_wdata;
        m_be         = w_own_be;
        m_burstcount = w_own_burst;
        for (int i = 0; i < NUM_SLAVES; i++) begin
          s_waitrequest[i] = (r_owner == OW'(i)) ? m_waitrequest : 1'b1;
        end
      end
      default: begin
        m_read = 1'b0;
      end
    endcase
  end

  // Steer each read beat to the slave at the head of the response FIFO.
  always_comb begin
    s_readdatavalid = {NUM_SLAVES{1'b0}};
    for (int i = 0; i < NUM_SLAVES; i++) begin
      s_readdatavalid[i] = w_rsp_hit & (w_head_id == OW'(i));
    end
  end

  // Arbitration FSM: IDLE -> GRANT -> (WBURST) -> IDLE.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
      r_owner <= LAST_SLAVE;
      r_wcnt  <= BEAT_ZERO;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_owner <= w_next_owner;
            r_state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (w_accept) begin
            if (m_read) begin
              r_state <= ST_IDLE;
            end else if (w_own_burst > BEAT_ONE) begin
              r_wcnt  <= w_own_burst - BEAT_ONE;
              r_state <= ST_WBURST;
            end else begin
              r_state <= ST_IDLE;
            end
          end else if (!(w_own_read | w_own_write)) begin
            r_state <= ST_IDLE;
          end
        end
        ST_WBURST: begin
          if (w_accept) begin
            r_wcnt <= r_wcnt - BEAT_ONE;
            if (r_wcnt <= BEAT_ONE) begin
              r_state <= ST_IDLE;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Response FIFO storage; contents are qualified by r_count so need no reset.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_fifo_id[r_wr_ptr]  <= r_owner;
      r_fifo_len[r_wr_ptr] <= w_own_len;
    end
  end

  // Response FIFO pointers/occupancy, beat counter and sticky error flag.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_wr_ptr <= PW'(0);
      r_rd_ptr <= PW'(0);
      r_count  <= CNT_ZERO;
      r_rcnt   <= BEAT_ZERO;
      r_err    <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
      if (w_pop) begin
        r_rcnt <= BEAT_ZERO;
      end else if (w_rsp_hit) begin
        r_rcnt <= r_rcnt + BEAT_ONE;
      end
      if (m_readdatavalid && w_empty) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_avl_rr_mux.sv
// Directed testbench for avl_rr_mux (5 slaves, 32-bit data, 16 response slots).
module tb_avl_rr_mux;

  localparam int NS  = 5;
  localparam int AW  = 27;
  localparam int DW  = 32;
  localparam int BW  = 7;
  localparam int BEW = DW / 8;

  logic              clock = 1'b0;
  logic              resetn;
  logic [NS*AW-1:0]  s_address;
  logic [NS-1:0]     s_read;
  logic [NS-1:0]     s_write;
  logic [NS*DW-1:0]  s_writedata;
  logic [NS*BEW-1:0] s_be;
  logic [NS*BW-1:0]  s_burstcount;
  logic [NS-1:0]     s_waitrequest;
  logic [NS*DW-1:0]  s_readdata;
  logic [NS-1:0]     s_readdatavalid;
  logic [AW-1:0]     m_address;
  logic              m_read;
  logic              m_write;
  logic [DW-1:0]     m_writedata;
  logic [BEW-1:0]    m_be;
  logic [BW-1:0]     m_burstcount;
  logic              m_waitrequest;
  logic [DW-1:0]     m_readdata;
  logic              m_readdatavalid;
  logic              err_unexpected_rsp;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  avl_rr_mux #(
    .NUM_SLAVES(NS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .BURST_WIDTH(BW), .RSP_FIFO_DEPTH(16)
  ) dut (
    .clock(clock), .resetn(resetn),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_be(s_be), .s_burstcount(s_burstcount),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .s_readdatavalid(s_readdatavalid),
    .m_address(m_address), .m_read(m_read), .m_write(m_write),
    .m_writedata(m_writedata), .m_be(m_be), .m_burstcount(m_burstcount),
    .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
    .m_readdatavalid(m_readdatavalid),
    .err_unexpected_rsp(err_unexpected_rsp)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  task automatic set_cmd(input int s, input logic rd, input logic wr,
                         input logic [AW-1:0] a, input logic [BW-1:0] bc,
                         input logic [DW-1:0] wd);
    s_read[s]                  = rd;
    s_write[s]                 = wr;
    s_address[s*AW +: AW]      = a;
    s_burstcount[s*BW +: BW]   = bc;
    s_writedata[s*DW +: DW]    = wd;
    s_be[s*BEW +: BEW]         = {BEW{1'b1}};
  endtask

  int          order2 [6] = '{1, 3, 4, 1, 3, 4};
  logic [4:0]  exp5 [5]   = '{5'b10000, 5'b10000, 5'b00001, 5'b00001, 5'b00001};
  logic [4:0]  e;
  int          beat;
  logic        acc;

  initial begin
    resetn = 1'b0;
    s_address = '0; s_read = '0; s_write = '0; s_writedata = '0;
    s_be = '0; s_burstcount = '0;
    m_waitrequest = 1'b0; m_readdata = '0; m_readdatavalid = 1'b0;

    // Reset values
    nxt(); nxt();
    check_val("rst_mread", m_read, 0);
    check_val("rst_mwrite", m_write, 0);
    check_val("rst_maddr", m_address, 0);
    check_val("rst_wait", s_waitrequest, 5'h1f);
    check_val("rst_rdv", s_readdatavalid, 0);
    check_val("rst_err", err_unexpected_rsp, 0);

    // Slave 0 read, address 0x10, burst 4
    resetn = 1'b1;
    set_cmd(0, 1'b1, 1'b0, 27'h10, 7'd4, 32'h0);
    #1;
    check_val("t1_bubble", m_read, 0);
    nxt();
    check_val("t1_mread", m_read, 1);
    check_val("t1_addr", m_address, 64'h10);
    check_val("t1_burst", m_burstcount, 4);
    check_val("t1_be", m_be, 4'hf);
    check_val("t1_wait", s_waitrequest, 5'h1e);
    nxt();
    s_read[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      m_readdatavalid = 1'b1;
      m_readdata = 32'ha0 + 32'(k);
      #1;
      check_val("t1_rdv", s_readdatavalid, 5'b00001);
      check_val("t1_rdata", s_readdata[4*DW +: DW], 64'ha0 + 64'(k));
      nxt();
    end
    m_readdatavalid = 1'b0;

    // Round-robin among slaves 1, 3, 4
    set_cmd(1, 1'b1, 1'b0, 27'h101, 7'd1, 32'h0);
    set_cmd(3, 1'b1, 1'b0, 27'h103, 7'd1, 32'h0);
    set_cmd(4, 1'b1, 1'b0, 27'h104, 7'd1, 32'h0);
    for (int g = 0; g < 6; g++) begin
      nxt();
      e = 5'h1f;
      e[order2[g]] = 1'b0;
      check_val("t2_grant", s_waitrequest, 64'(e));
      check_val("t2_addr", m_address, 64'h100 + 64'(order2[g]));
      nxt();
      check_val("t2_idle", m_read, 0);
    end
    s_read = '0;
    for (int k = 0; k < 6; k++) begin
      m_readdatavalid = 1'b1;
      #1;
      e = 5'h00;
      e[order2[k]] = 1'b1;
      check_val("t2_rsp_id", s_readdatavalid, 64'(e));
      nxt();
    end
    m_readdatavalid = 1'b0;

    // Slave 2 write burst 8 with waitrequest toggling; slave 0 waits
    set_cmd(2, 1'b0, 1'b1, 27'h200, 7'd8, 32'h2000);
    nxt();
    set_cmd(0, 1'b1, 1'b0, 27'h40, 7'd1, 32'h0);
    beat = 0;
    for (int c = 0; c < 40 && beat < 8; c++) begin
      m_waitrequest = (c % 2 == 0);
      s_writedata[2*DW +: DW] = 32'h2000 + 32'(beat);
      #1;
      check_val("t3_mwrite", m_write, 1);
      check_val("t3_wdata", m_writedata, 64'h2000 + 64'(beat));
      check_val("t3_mread", m_read, 0);
      check_val("t3_wait", s_waitrequest, m_waitrequest ? 5'h1f : 5'h1b);
      acc = ~m_waitrequest;
      nxt();
      if (acc) beat++;
    end
    check_val("t3_beats", beat, 8);
    m_waitrequest = 1'b0;
    s_write[2] = 1'b0;
    #1;
    check_val("t3_idle_mwrite", m_write, 0);
    check_val("t3_idle_wait", s_waitrequest, 5'h1f);
    nxt();
    check_val("t3_s0_wait", s_waitrequest, 5'h1e);
    check_val("t3_s0_mread", m_read, 1);
    check_val("t3_s0_addr", m_address, 64'h40);
    nxt();
    s_read[0] = 1'b0;
    m_readdatavalid = 1'b1;
    #1;
    check_val("t3_s0_rdv", s_readdatavalid, 5'b00001);
    nxt();
    m_readdatavalid = 1'b0;

    // 16 outstanding reads from slave 1 fill the FIFO
    set_cmd(1, 1'b1, 1'b0, 27'h111, 7'd1, 32'h0);
    for (int g = 0; g < 16; g++) begin
      nxt();
      check_val("t4_mread", m_read, 1);
      nxt();
    end
    nxt();
    check_val("t4_full_mread", m_read, 0);
    check_val("t4_full_wait", s_waitrequest, 5'h1f);
    nxt();
    check_val("t4_full_mread2", m_read, 0);
    m_readdatavalid = 1'b1;
    #1;
    check_val("t4_rdv", s_readdatavalid, 5'b00010);
    check_val("t4_pop_mread", m_read, 0);
    nxt();
    m_readdatavalid = 1'b0;
    #1;
    check_val("t4_free_mread", m_read, 1);
    check_val("t4_free_wait", s_waitrequest, 5'h1d);
    nxt();
    s_read[1] = 1'b0;
    for (int k = 0; k < 16; k++) begin
      m_readdatavalid = 1'b1;
      #1;
      check_val("t4_drain", s_readdatavalid, 5'b00010);
      nxt();
    end
    m_readdatavalid = 1'b0;

    // Interleaved reads: slave 4 len 2, then slave 0 len 3
    set_cmd(4, 1'b1, 1'b0, 27'h44, 7'd2, 32'h0);
    set_cmd(0, 1'b1, 1'b0, 27'h4, 7'd3, 32'h0);
    nxt();
    check_val("t5_g4_wait", s_waitrequest, 5'h0f);
    check_val("t5_g4_burst", m_burstcount, 2);
    nxt();
    s_read[4] = 1'b0;
    nxt();
    check_val("t5_g0_wait", s_waitrequest, 5'h1e);
    check_val("t5_g0_burst", m_burstcount, 3);
    nxt();
    s_read[0] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      m_readdatavalid = 1'b1;
      #1;
      check_val("t5_rsp", s_readdatavalid, 64'(exp5[k]));
      nxt();
    end
    m_readdatavalid = 1'b0;

    // Unexpected response beat
    m_readdatavalid = 1'b1;
    #1;
    check_val("t6_rdv", s_readdatavalid, 0);
    nxt();
    m_readdatavalid = 1'b0;
    #1;
    check_val("t6_err", err_unexpected_rsp, 1);
    nxt();
    check_val("t6_err_sticky", err_unexpected_rsp, 1);

    // Reset in the middle of a write burst
    set_cmd(3, 1'b0, 1'b1, 27'h33, 7'd4, 32'h3300);
    nxt();
    check_val("t7_grant", m_write, 1);
    nxt();
    nxt();
    check_val("t7_burst", m_write, 1);
    resetn = 1'b0;
    s_write[3] = 1'b0;
    #1;
    check_val("t7_inrst", m_write, 0);
    nxt();
    resetn = 1'b1;
    #1;
    check_val("t7_mwrite", m_write, 0);
    check_val("t7_wait", s_waitrequest, 5'h1f);
    check_val("t7_err", err_unexpected_rsp, 0);
    set_cmd(0, 1'b1, 1'b0, 27'h5, 7'd1, 32'h0);
    set_cmd(1, 1'b1, 1'b0, 27'h6, 7'd1, 32'h0);
    nxt();
    check_val("t7_first_owner", s_waitrequest, 5'h1e);
    s_read = '0;
    nxt();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
